fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Owns the program counter and sequences the combinational, byte-addressed, big-endian instruction memory: one 32-bit word fetched per cycle.
- Fetched {pc, instruction} pairs are buffered in a small queue and handed to decode with a valid/ready handshake.
- Accepts branch redirects from execute, which flush the queue.
- Halts cleanly when the PC leaves the populated memory range or a redirect target is misaligned.

Parameters:
- IMEM_BYTES, 64, instruction memory size in bytes (16 words).
- RESET_PC, 64'h0, PC loaded at reset.
- QDEPTH, 2, fetch queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  fetch enable; low freezes the PC and stops pushes (pops continue).
- redirect_valid  in  1  branch taken / redirect request.
- redirect_pc  in  64  redirect target byte address.
- imem_addr  out  64  address to instruction memory; equals the PC register (combinational).
- imem_instr  in  32  instruction returned by memory in the same cycle.
- out_valid  out  1  queue head is valid.
- out_instr  out  32  queue head instruction.
- out_pc  out  64  queue head PC.
- out_ready  in  1  decode accepts the head this cycle.
- halted  out  1  state == HALT.
- misalign  out  1  sticky; the last redirect target had pc[1:0] != 0.

Behaviour:
- Reset (async): PC = RESET_PC, queue empty, state = IDLE, out_valid = 0, out_instr = 0, out_pc = 0, halted = 0, misalign = 0.
- States:
  - IDLE -> RUN when en = 1.
  - RUN -> IDLE when en = 0.
  - RUN -> HALT when PC + 4 > IMEM_BYTES, or on a misaligned redirect.
  - HALT -> RUN only on an aligned, in-range redirect.
- Push (RUN only): requires en = 1, no redirect_valid, PC + 4 <= IMEM_BYTES, and the queue not full (or a pop in the same cycle).
  - Effect: enqueue {PC, imem_instr}, then PC += 4.
- Pop: occurs when out_valid && out_ready. Simultaneous push and pop are allowed in the same cycle, including when the queue is full.
- Latency: en rises at edge 0 (IDLE -> RUN); push at edge 1; out_valid = 1 after edge 1. Sustained throughput is 1 instruction per cycle while out_ready = 1.
- Redirect has highest priority and applies in any state except while rst is high:
  - Queue flushed; no push or pop that cycle; out_valid = 0 after the edge.
  - Aligned target: PC = redirect_pc, misalign cleared.
  - Target >= IMEM_BYTES: PC = redirect_pc, state = HALT.
  - Misaligned target: PC unchanged, misalign = 1, state = HALT.
  - The first post-redirect instruction is visible one edge after the redirect edge (if en = 1).
- HALT: no pushes; queued entries still drain; halted = 1.
- Backpressure: with out_ready = 0 the queue fills to QDEPTH, then PC holds. out_instr and out_pc must stay stable while out_valid = 1 and out_ready = 0.
- Arithmetic: PC is an unsigned 64-bit value. The range check uses a 65-bit sum so PC near 2^64 cannot wrap to an in-range value.
- en = 0 mid-stream: PC holds, the queue keeps its contents and still drains.
- Reset mid-operation: immediate return to the reset values, independent of the clock.

Decomposition:
- Shared package fetch_pkg:
  - ADDR_W = 64, INSTR_W = 32, INSTR_BYTES = 4.
  - fetch_state_t enum {IDLE, RUN, HALT}.
  - fetch_entry_t struct {pc, instr}.
- Sub-module fetch_queue:
  - Parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count.
  - Flush beats push, which must not happen in the same cycle anyway.
  - Same async active-high reset.
- Everything else (PC register, FSM, range/align checks) lives in fetch_sequencer.

Test Plan:
- Reset, en = 1, out_ready = 1, memory loaded with the standard 12-word test program:
  - out_pc sequence is 0, 4, 8, 12; out_instr sequence is F8400142, F8401143, CB020064, 8B020065.
  - First out_valid follows edge 1.
- out_ready = 0 for 5 cycles after the first fill: queue count reaches 2, imem_addr holds at 8, out_pc/out_instr stay stable at 0/F8400142. Releasing out_ready resumes the sequence with no gaps or duplicates.
- Redirect to 28 while the queue holds PCs 16 and 20:
  - Queue flushed; next out_pc = 28 with instruction AA030046.
  - No entry for PC 16 or 20 appears.
- Sequential run to the end of memory:
  - Last push is PC 60; halted = 1 when PC = 64.
  - Queue drains, then out_valid = 0.
  - Redirect to 0 resumes with out_pc = 0.
- Redirect to 0x22: misalign = 1, halted = 1, PC unchanged. A following redirect to 0x24 clears misalign and resumes with out_pc = 0x24.
- Assert rst asynchronously mid-stream with 2 entries queued: outputs go to their reset values before the next edge, PC = RESET_PC, and the queue is empty.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the instruction fetch path
package fetch_pkg;

    localparam int ADDR_W      = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO of {pc, instr} fetch entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output fetch_entry_t             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [PW-1:0]  r_rd;
    logic [PW-1:0]  r_wr;
    logic [PW:0]    r_count;
    logic           w_wr_en;
    logic           w_rd_en;

    assign w_wr_en = i_push && !i_flush;
    assign w_rd_en = i_pop && !i_flush;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC register, fetch FSM and redirect handling
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          IMEM_BYTES = 64,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          QDEPTH     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    output logic                out_valid,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    input  logic                out_ready,
    output logic                halted,
    output logic                misalign
);

    fetch_state_t               r_state;
    fetch_state_t               w_state_next;
    logic [ADDR_W-1:0]          r_pc;
    logic                       r_misalign;

    logic [ADDR_W:0]            w_pc_sum;
    logic                       w_pc_in_range;
    logic                       w_redir_misaligned;
    logic                       w_redir_oob;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic [$clog2(QDEPTH):0]    w_q_count_unused;
    fetch_entry_t               w_push_entry;
    fetch_entry_t               w_head;

    // 65-bit sum so a PC near 2^64 cannot wrap back into range.
    assign w_pc_sum           = {1'b0, r_pc} + (ADDR_W+1)'(INSTR_BYTES);
    assign w_pc_in_range      = (w_pc_sum <= (ADDR_W+1)'(IMEM_BYTES));
    assign w_redir_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_redir_oob        = (redirect_pc >= ADDR_W'(IMEM_BYTES));

    assign w_pop  = out_valid && out_ready && !redirect_valid;
    assign w_push = (r_state == RUN) && en && !redirect_valid && w_pc_in_range
                    && (!w_full || w_pop);

    assign w_push_entry = '{pc: r_pc, instr: imem_instr};

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            if (w_redir_misaligned || w_redir_oob) begin
                w_state_next = HALT;
            end else if (r_state == HALT || en) begin
                w_state_next = RUN;
            end else begin
                w_state_next = IDLE;
            end
        end else begin
            case (r_state)
                IDLE: if (en) w_state_next = RUN;
                RUN: begin
                    if (!en) begin
                        w_state_next = IDLE;
                    end else if (!w_pc_in_range) begin
                        w_state_next = HALT;
                    end
                end
                default: w_state_next = HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (redirect_valid) begin
                r_misalign <= w_redir_misaligned;
                // A misaligned target leaves the PC where it was.
                if (!w_redir_misaligned) begin
                    r_pc <= redirect_pc;
                end
            end else if (w_push) begin
                r_pc <= r_pc + ADDR_W'(INSTR_BYTES);
            end
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_q_count_unused)
    );

    assign imem_addr = r_pc;
    assign out_valid = !w_empty;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;
    assign halted    = (r_state == HALT);
    assign misalign  = r_misalign;

endmodule
